muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit owning the architectural HI/LO registers. It replaces the single-cycle combinational multiply path in the ALU. Execute hands it operands with a one-cycle `start` pulse. The unit iterates for a fixed number of cycles while the pipeline stalls on `busy`, then writes HI/LO and pulses `done`. It also supports signed/unsigned division, divide-by-zero detection, direct HI/LO writes (MTHI/MTLO) and abort on pipeline flush.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_iter.sv | 35 +++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and op-decode helpers for the multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage to multiply/divide unit bundle: launch, direct HI/LO writes, status and results.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_iter.sv
// One iteration on the 2*WIDTH accumulator: shift-add multiply step or restoring-divide step.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : (WIDTH+1)'(0));

    // Divide: acc = {partial remainder, dividend bits becoming quotient bits}, shifted left.
    assign div_shift = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_i};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

    always_comb begin
        acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        if (is_div) begin
            acc_o = {div_rem, acc_i[WIDTH-2:0], div_ge};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; iterates one bit per cycle, sign-fixes, then writes back.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic    clk,
    input  logic    resetn,
    muldiv_if.slave md
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned W2 = 2 * WIDTH;

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             launch;
    logic             in_signed;
    logic             in_a_neg;
    logic             in_b_neg;
    logic [W2-1:0]    acc_step;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign launch    = md.start & ~md.flush;
    assign in_signed = op_is_signed(md.op);
    assign in_a_neg  = in_signed & md.a[WIDTH-1];
    assign in_b_neg  = in_signed & md.b[WIDTH-1];

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div (is_div_q),
        .acc_i  (acc_q),
        .b_i    (mag_b_q),
        .acc_o  (acc_step)
    );

    // Sign correction applied in FIX; 0x80..0 / -1 falls out naturally as 0x80..0 rem 0.
    assign prod_fix = neg_res_q ? (~acc_q + W2'(1)) : acc_q;
    assign quot_fix = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = (op_is_div(md.op) && (md.b == '0)) ? ST_FIX : ST_CALC;
                end
            end
            ST_CALC: begin
                if (md.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        mag_b_d       = mag_b_q;
        is_div_d      = is_div_q;
        neg_res_d     = neg_res_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = 1'b0;
        div_by_zero_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (md.hi_we) hi_d = md.wdata;
                if (md.lo_we) lo_d = md.wdata;
                if (launch) begin
                    cnt_d     = '0;
                    acc_d     = {WIDTH'(0), (in_a_neg ? (~md.a + WIDTH'(1)) : md.a)};
                    mag_b_d   = in_b_neg ? (~md.b + WIDTH'(1)) : md.b;
                    is_div_d  = op_is_div(md.op);
                    neg_res_d = in_a_neg ^ in_b_neg;
                    neg_rem_d = in_a_neg;
                    dbz_d     = op_is_div(md.op) && (md.b == '0);
                end
            end
            ST_CALC: begin
                if (!md.flush) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_FIX: begin
                if (!md.flush) begin
                    done_d        = 1'b1;
                    div_by_zero_d = dbz_q;
                    if (!dbz_q) begin
                        if (is_div_q) begin
                            lo_d = quot_fix;
                            hi_d = rem_fix;
                        end else begin
                            lo_d = prod_fix[WIDTH-1:0];
                            hi_d = prod_fix[W2-1:WIDTH];
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            mag_b_q       <= '0;
            is_div_q      <= 1'b0;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            mag_b_q       <= mag_b_d;
            is_div_q      <= is_div_d;
            neg_res_q     <= neg_res_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign md.busy        = (state_q != ST_IDLE);
    assign md.done        = done_q;
    assign md.div_by_zero = div_by_zero_q;
    assign md.hi          = hi_q;
    assign md.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of mul/div results plus hand sequences for corner cases.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } vec_t;

    logic clk;
    logic resetn;
    int   n_total;
    int   n_pass;
    vec_t vecs[11];

    muldiv_if #(.WIDTH(W)) md ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .md     (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the start edge.
    task automatic launch(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        md.start = 1'b1;
        md.op    = op;
        md.a     = a;
        md.b     = b;
        @(negedge clk);
        md.start = 1'b0;
        chk({name, "_busy_after_start"}, W'(md.busy), W'(1));
        chk({name, "_done_low_after_start"}, W'(md.done), W'(0));
    endtask

    task automatic wait_done(input int max_cycles, output int n);
        n = 0;
        while (!md.done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_op(input string name, input int lat0, input logic [W-1:0] ehi,
                             input logic [W-1:0] elo, input logic edbz, input int elat);
        int n;
        wait_done(100, n);
        chk({name, "_latency"}, W'(lat0 + n), W'(elat));
        chk({name, "_hi"}, md.hi, ehi);
        chk({name, "_lo"}, md.lo, elo);
        chk({name, "_dbz"}, W'(md.div_by_zero), W'(edbz));
        chk({name, "_busy_low_at_done"}, W'(md.busy), W'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_total = 0;
        n_pass  = 0;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[3]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
        vecs[4]  = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 34};
        vecs[5]  = '{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, 34};
        vecs[6]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[7]  = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 34};
        vecs[8]  = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 34};
        vecs[9]  = '{MD_MULT,  32'h0000_0000, 32'h0000_3039, 32'h0000_0000, 32'h0000_0000, 1'b0, 34};
        vecs[10] = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 34};

        resetn   = 1'b0;
        md.start = 1'b0;
        md.op    = 2'b00;
        md.a     = '0;
        md.b     = '0;
        md.flush = 1'b0;
        md.hi_we = 1'b0;
        md.lo_we = 1'b0;
        md.wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_hi", md.hi, '0);
        chk("reset_lo", md.lo, '0);
        chk("reset_busy", W'(md.busy), W'(0));
        chk("reset_done", W'(md.done), W'(0));
        chk("reset_dbz", W'(md.div_by_zero), W'(0));
        resetn = 1'b1;
        @(negedge clk);

        // Back-to-back: each launch happens in the done cycle of the previous op.
        for (int i = 0; i < 11; i++) begin
            launch($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
            finish_op($sformatf("vec%0d", i), 1, vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat);
        end
        @(negedge clk);
        chk("done_single_cycle", W'(md.done), W'(0));

        // Divide by zero with preloaded HI/LO.
        md.hi_we = 1'b1; md.wdata = 32'h11;
        @(negedge clk);
        md.hi_we = 1'b0; md.lo_we = 1'b1; md.wdata = 32'h22;
        @(negedge clk);
        md.lo_we = 1'b0;
        chk("preload_hi", md.hi, 32'h11);
        chk("preload_lo", md.lo, 32'h22);
        launch("divu_by_zero", MD_DIVU, 32'h7, 32'h0);
        finish_op("divu_by_zero", 1, 32'h11, 32'h22, 1'b1, 2);
        @(negedge clk);
        chk("dbz_single_cycle", W'(md.div_by_zero), W'(0));

        // Direct write on the start edge lands, then the result overwrites it; writes while busy drop.
        md.hi_we = 1'b1; md.wdata = 32'hAB;
        launch("write_with_start", MD_MULTU, 32'h3, 32'h4);
        chk("write_with_start_hi_landed", md.hi, 32'hAB);
        md.wdata = 32'hCD;
        @(negedge clk);
        chk("write_while_busy_dropped", md.hi, 32'hAB);
        md.hi_we = 1'b0;
        finish_op("write_with_start", 2, 32'h0, 32'hC, 1'b0, 34);

        // start while busy is ignored.
        launch("start_while_busy", MD_MULTU, 32'h6, 32'h7);
        repeat (5) @(negedge clk);
        md.start = 1'b1; md.op = MD_DIVU; md.a = 32'h64; md.b = 32'h0;
        @(negedge clk);
        md.start = 1'b0;
        finish_op("start_while_busy", 7, 32'h0, 32'h2A, 1'b0, 34);

        // Flush mid-CALC with an attempted write, then immediate restart.
        md.hi_we = 1'b1; md.wdata = 32'h55;
        @(negedge clk);
        md.hi_we = 1'b0; md.lo_we = 1'b1; md.wdata = 32'h66;
        @(negedge clk);
        md.lo_we = 1'b0;
        launch("flush", MD_MULTU, 32'hFFFF_FFFF, 32'h2);
        repeat (8) @(negedge clk);
        md.flush = 1'b1; md.hi_we = 1'b1; md.wdata = 32'hDEAD;
        @(negedge clk);
        md.flush = 1'b0; md.hi_we = 1'b0;
        chk("flush_idle_next", W'(md.busy), W'(0));
        wait_done(40, n);
        chk("flush_no_done_cycles", W'(n), W'(40));
        chk("flush_hi_kept", md.hi, 32'h55);
        chk("flush_lo_kept", md.lo, 32'h66);
        launch("restart", MD_MULTU, 32'hFFFF_FFFF, 32'h2);
        finish_op("restart", 1, 32'h1, 32'hFFFF_FFFE, 1'b0, 34);

        // flush together with start in IDLE blocks the launch.
        md.start = 1'b1; md.flush = 1'b1; md.op = MD_MULTU; md.a = 32'h9; md.b = 32'h9;
        @(negedge clk);
        md.start = 1'b0; md.flush = 1'b0;
        chk("flush_start_no_busy", W'(md.busy), W'(0));
        wait_done(40, n);
        chk("flush_start_no_done_cycles", W'(n), W'(40));
        chk("flush_start_lo_kept", md.lo, 32'hFFFF_FFFE);

        // Reset mid-CALC clears everything asynchronously.
        launch("reset_mid", MD_MULT, 32'h1234, 32'h5678);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("reset_mid_hi", md.hi, '0);
        chk("reset_mid_lo", md.lo, '0);
        chk("reset_mid_busy", W'(md.busy), W'(0));
        chk("reset_mid_done", W'(md.done), W'(0));
        chk("reset_mid_dbz", W'(md.div_by_zero), W'(0));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        launch("after_reset", MD_DIVU, 32'h64, 32'h7);
        finish_op("after_reset", 1, 32'h2, 32'hE, 1'b0, 34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
